// File: rtl/data_mem_ctrl.sv
// Multi-cycle data memory for the MEM stage: holds the pipeline for WAIT_CYCLES
// wait states, then completes one load or store with a one-cycle done pulse.
module data_mem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_En,
    input  logic        write_En,
    input  logic [31:0] DataAddress,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic [1:0]  dbg_state
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [3:0]     cnt, cnt_nx;
    logic [IW-1:0]  idx_q;
    logic [31:0]    wdata_q;
    logic           we_q;
    logic [31:0]    mem [DEPTH];

    logic           req, illegal, capture;
    logic           acc_fire, acc_ill, acc_we;
    logic [IW-1:0]  acc_idx;
    logic [31:0]    acc_wdata;

    // Handshake: a request (read_En|write_En) is taken in IDLE; the requester
    // must hold it stable while stall=1 and sees completion when done=1.
    assign req     = read_En | write_En;
    assign illegal = (DataAddress[1:0] != 2'b00) || (DataAddress[31:2] >= 30'(DEPTH));

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        capture   = 1'b0;
        acc_fire  = 1'b0;
        acc_ill   = 1'b0;
        acc_we    = we_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        case (state)
            S_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (illegal) begin
                        state_nx = S_DONE;
                        acc_fire = 1'b1;
                        acc_ill  = 1'b1;
                        acc_we   = 1'b0;
                    end else if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access uses the live inputs.
                        state_nx  = S_DONE;
                        acc_fire  = 1'b1;
                        acc_we    = write_En;
                        acc_idx   = DataAddress[IW+1:2];
                        acc_wdata = WriteData;
                    end else begin
                        state_nx = S_BUSY;
                        cnt_nx   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_BUSY: begin
                if (cnt == 4'd1) begin
                    state_nx = S_DONE;
                    cnt_nx   = 4'd0;
                    acc_fire = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            ReadData <= 32'd0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (capture) begin
                idx_q   <= DataAddress[IW+1:2];
                wdata_q <= WriteData;
                we_q    <= write_En;
            end
            if (acc_fire) begin
                if (acc_ill) begin
                    ReadData <= 32'd0;
                    err      <= 1'b1;
                end else begin
                    err <= 1'b0;
                    if (!acc_we) ReadData <= mem[acc_idx];
                end
            end
        end
    end

    // Contents are not reset; reset only suppresses an in-flight write.
    always_ff @(posedge clk) begin
        if (!reset && acc_fire && acc_we && !acc_ill) mem[acc_idx] <= acc_wdata;
    end

    assign done      = (state == S_DONE);
    assign stall     = !reset && (((state == S_IDLE) && req) || (state == S_BUSY));
    assign dbg_state = state;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with two wait states and one
// with zero wait states, checked against hand-computed values.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        re1, we1, re0, we0;
  logic [31:0] addr1, wd1, addr0, wd0;
  logic [31:0] rd1, rd0;
  logic        done1, stall1, err1, done0, stall0, err0;
  logic [1:0]  st1, st0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .read_En(re1), .write_En(we1),
    .DataAddress(addr1), .WriteData(wd1), .ReadData(rd1),
    .done(done1), .stall(stall1), .err(err1), .dbg_state(st1)
  );

  data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .read_En(re0), .write_En(we0),
    .DataAddress(addr0), .WriteData(wd0), .ReadData(rd0),
    .done(done0), .stall(stall0), .err(err0), .dbg_state(st0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic re, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      re0 = re; we0 = we; addr0 = a; wd0 = d;
    end else begin
      re1 = re; we1 = we; addr1 = a; wd1 = d;
    end
  endtask

  // Issue one request, wait for done, check latency, stall span and results.
  task automatic access(input bit sel, input string tag, input logic re, input logic we,
                        input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                        input logic exp_err, input bit chk_rd, input logic [31:0] exp_rd,
                        input bit scramble);
    int cyc = 0;
    int stalls = 0;
    bit got = 0;
    drive(sel, re, we, a, d);
    while (cyc < 40) begin
      @(negedge clk);
      if (sel ? done0 : done1) begin
        got = 1;
        break;
      end
      stalls += int'(sel ? stall0 : stall1);
      cyc++;
      @(posedge clk); #1;
      if (scramble) drive(sel, re, we, $urandom, $urandom);
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_lat));
    chk({tag, "_stall_at_done"}, 32'(sel ? stall0 : stall1), 32'd0);
    chk({tag, "_err"}, 32'(sel ? err0 : err1), 32'(exp_err));
    if (chk_rd) chk({tag, "_rd"}, sel ? rd0 : rd1, exp_rd);
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(sel ? done0 : done1), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int pulses;
    int stall_sum;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    re1 = 1'b1;
    @(negedge clk);
    chk("rst_stall_with_req", 32'(stall1), 32'd0);
    chk("rst_rd", rd1, 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_state", 32'(st1), 32'd0);
    chk("rst_rd_w0", rd0, 32'd0);
    re1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    pulses = 0;
    stall_sum = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pulses += int'(done1);
      stall_sum += int'(stall1);
      @(posedge clk); #1;
    end
    chk("idle_done", 32'(pulses), 32'd0);
    chk("idle_stall", 32'(stall_sum), 32'd0);
    chk("idle_rd", rd1, 32'd0);
    chk("idle_err", 32'(err1), 32'd0);

    access(0, "st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, 0, 32'd0, 0);
    access(0, "st00", 1'b0, 1'b1, 32'h0, 32'h11110000, 3, 1'b0, 0, 32'd0, 0);
    access(0, "st08", 1'b0, 1'b1, 32'h8, 32'h0BADF00D, 3, 1'b0, 0, 32'd0, 0);
    access(0, "ld10", 1'b1, 1'b0, 32'h10, 32'd0, 3, 1'b0, 1, 32'hDEADBEEF, 0);
    access(0, "ld13", 1'b1, 1'b0, 32'h13, 32'd0, 1, 1'b1, 1, 32'd0, 0);
    access(0, "st400", 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 1, 1'b1, 1, 32'd0, 0);
    access(0, "ld00", 1'b1, 1'b0, 32'h0, 32'd0, 3, 1'b0, 1, 32'h11110000, 0);
    access(0, "ld10b", 1'b1, 1'b0, 32'h10, 32'd0, 3, 1'b0, 1, 32'hDEADBEEF, 0);
    access(0, "both20", 1'b1, 1'b1, 32'h20, 32'h12345678, 3, 1'b0, 1, 32'hDEADBEEF, 0);
    access(0, "ld20", 1'b1, 1'b0, 32'h20, 32'd0, 3, 1'b0, 1, 32'h12345678, 0);
    access(0, "st24_scr", 1'b0, 1'b1, 32'h24, 32'h600DCAFE, 3, 1'b0, 0, 32'd0, 1);
    access(0, "ld24", 1'b1, 1'b0, 32'h24, 32'd0, 3, 1'b0, 1, 32'h600DCAFE, 0);

    // Abort a store by asserting reset on its second BUSY cycle.
    pulses = 0;
    drive(0, 1'b0, 1'b1, 32'h8, 32'hAAAA5555);
    @(negedge clk);
    pulses += int'(done1);
    @(posedge clk); #1;
    @(negedge clk);
    pulses += int'(done1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy2_state", 32'(st1), 32'd1);
    pulses += int'(done1);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_state_idle", 32'(st1), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pulses += int'(done1);
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    access(0, "ld08", 1'b1, 1'b0, 32'h8, 32'd0, 3, 1'b0, 1, 32'h0BADF00D, 0);

    access(1, "w0_st04", 1'b0, 1'b1, 32'h4, 32'h00C0FFEE, 1, 1'b0, 0, 32'd0, 0);
    access(1, "w0_ld04", 1'b1, 1'b0, 32'h4, 32'd0, 1, 1'b0, 1, 32'h00C0FFEE, 0);
    access(1, "w0_ld400", 1'b1, 1'b0, 32'h400, 32'd0, 1, 1'b1, 1, 32'd0, 0);
    access(1, "w0_ld04b", 1'b1, 1'b0, 32'h4, 32'd0, 1, 1'b0, 1, 32'h00C0FFEE, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Multi-cycle data memory with a wait-state controller, sitting directly downstream of the EX stage. It is the data memory the MEM stage accesses. It accepts one load or store per request from the MEM-stage control signals. It holds the pipeline with `stall` for a programmable number of wait states. It returns registered read data with a one-cycle `done` pulse and flags misaligned or out-of-range accesses.

## Interface
- `DEPTH`, 256, number of 32-bit words; power of two, at most 65536.
- `WAIT_CYCLES`, 2, wait states per access; legal range 0..15.
- `clk`  in  1  pipeline clock; every register is updated on its rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `read_En`  in  1  load request from the MEM stage; held stable while `stall`=1.
- `write_En`  in  1  store request; held stable while `stall`=1.
- `DataAddress`  in  32  byte address, from the ALU result.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  registered load data.
- `done`  out  1  one-cycle pulse marking access completion.
- `stall`  out  1  combinational hold request to the pipeline.
- `err`  out  1  registered; valid together with `done`.

## Operation
- FSM states are IDLE, BUSY and DONE. A request is `req = read_En | write_En`.
- If `read_En` and `write_En` are both high, the access is a store and the read is ignored.
- Word index is `DataAddress[31:2]`.
- An access is illegal when `DataAddress[1:0] != 0` or when the word index is `>= DEPTH`.
- IDLE with `req` = 1:
  - Capture address, data and the op type.
  - Illegal access, or `WAIT_CYCLES` = 0: go to DONE.
  - Otherwise: go to BUSY with `cnt = WAIT_CYCLES`.
- BUSY:
  - `cnt == 1`: perform the access and go to DONE.
  - Otherwise: `cnt <= cnt - 1`.
- The access itself:
  - A store writes `mem[idx]` on the edge that enters DONE.
  - A load registers `ReadData <= mem[idx]` on the same edge.
  - With `WAIT_CYCLES` = 0, the access happens on the IDLE->DONE edge.
- Illegal access:
  - Memory is not written.
  - `ReadData <= 0` and `err <= 1`.
- DONE:
  - `done` = 1 for exactly one cycle, then the FSM returns to IDLE.
  - `req` is ignored in DONE. The pipeline advances on the DONE edge, so a back-to-back request is first sampled in the following IDLE cycle. This costs one bubble cycle per access.
- `stall = (IDLE & req) | BUSY`. `stall` is 0 in DONE and in IDLE without a request.
- `ReadData` holds its value until the next completed load or illegal access. A completed store leaves it unchanged.
- `err` is cleared on every legal completion.
- Memory contents are not reset. The bench initialises memory by writes.

## Timing
- Reset values: state IDLE, `cnt` = 0, `ReadData` = 0, `done` = 0, `err` = 0. `stall` = 0 while `reset` is high.
- Latency: with a legal request first seen in IDLE at cycle T, `done` = 1 at T + `WAIT_CYCLES` + 1.
- `stall` is 1 from T through T + `WAIT_CYCLES`, and 0 at the `done` cycle.
- Illegal access: `done` and `err` are 1 at T + 1; `stall` is 1 only at T.
- Reset asserted in BUSY aborts the access: no memory write, `done` is never pulsed, and the FSM returns to IDLE.
- Request inputs that change while `stall` = 1 have no effect, because address and data were captured at acceptance.
- Throughput is one access per `WAIT_CYCLES` + 2 cycles.

## Test plan
- Reset then idle: all outputs 0 and no `done` pulse for 10 cycles with `req` = 0.
- Store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to address 0x10: `stall` is high 3 cycles, then `done` pulses.
  - Load from 0x10: `ReadData` = 0xDEADBEEF with `done` at T+3 and `err` = 0.
- WAIT_CYCLES=0: a load is accepted at T; `done` is at T+1 and `stall` is high only at T.
- Illegal accesses:
  - Load at 0x13: `done` and `err` = 1 at T+1 and `ReadData` = 0.
  - Store at 0x400 with DEPTH=256: `err` = 1, and a later load of word 0 is unchanged.
- Simultaneous `read_En`=`write_En`=1 to 0x20 with data 0x12345678: treated as a store; `ReadData` is unchanged, and a later load returns 0x12345678.
- Reset asserted on the 2nd BUSY cycle of a store of 0xAAAA5555 to 0x8: no `done` pulse, and a later load of 0x8 returns its prior value.
